// File: rtl/tdc_multi_timer_if.sv
// Readout channel of the multi-channel timer: one captured interval per
// valid/ready transfer, tagged with channel index and overflow flag.
interface tdc_multi_timer_if #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result_data;
  logic [CW-1:0]    result_chan;
  logic             result_overflow;

  modport master (
    output result_valid,
    output result_data,
    output result_chan,
    output result_overflow,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result_data,
    input  result_chan,
    input  result_overflow,
    output result_ready
  );
endinterface

// File: rtl/tdc_multi_timer.sv
// Multi-channel interval timer: one start launches all counters, each channel
// freezes on a rising edge of its stop input, results are read out serially.
module tdc_multi_timer #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter bit OVF_STOP = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                start,
  input  logic [CHANNELS-1:0] stop_in,
  tdc_multi_timer_if.master   res,
  output logic                busy,
  output logic                done
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0]    LAST_IDX = CW'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_READ = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]              running_q, running_d;
  logic [CHANNELS-1:0]              ovf_q, ovf_d;
  logic [CHANNELS-1:0]              stop_prev_q, stop_prev_d;
  logic [CW-1:0]                    rd_idx_q, rd_idx_d;
  logic                             done_q, done_d;
  logic [CHANNELS-1:0]              stop_edge;
  logic                             accept;

  // Counter step at all-ones either saturates or wraps, selected by OVF_STOP.
  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] c);
    if (c != CNT_MAX) return c + WIDTH'(1);
    return OVF_STOP ? CNT_MAX : '0;
  endfunction

  assign stop_edge = stop_in & ~stop_prev_q;
  assign accept    = res.result_valid & res.result_ready;

  // State register and all capture flops
  always_ff @(posedge clk) begin
    if (reset | clear) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      running_q   <= '0;
      ovf_q       <= '0;
      stop_prev_q <= '0;
      rd_idx_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      running_q   <= running_d;
      ovf_q       <= ovf_d;
      stop_prev_q <= stop_prev_d;
      rd_idx_q    <= rd_idx_d;
      done_q      <= done_d;
    end
  end

  // Per-channel counting; a stop edge wins over the overflow step on all-ones.
  always_comb begin
    cnt_d       = cnt_q;
    running_d   = running_q;
    ovf_d       = ovf_q;
    stop_prev_d = stop_in;
    if (state_q == S_IDLE && start) begin
      cnt_d     = '0;
      running_d = '1;
      ovf_d     = '0;
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (running_q[i]) begin
          if (stop_edge[i]) begin
            running_d[i] = 1'b0;
          end else begin
            cnt_d[i] = count_step(cnt_q[i]);
            if (cnt_q[i] == CNT_MAX) begin
              ovf_d[i] = 1'b1;
              if (OVF_STOP) running_d[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (running_d == '0) begin
          state_d  = S_READ;
          rd_idx_d = '0;
        end
      end
      S_READ: begin
        if (accept) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = S_IDLE;
            rd_idx_d = '0;
            done_d   = 1'b1;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    res.result_valid    = (state_q == S_READ);
    res.result_data     = cnt_q[rd_idx_q];
    res.result_chan     = rd_idx_q;
    res.result_overflow = ovf_q[rd_idx_q];
    busy                = (state_q != S_IDLE);
    done                = done_q;
  end
endmodule
